// File: rtl/exec_stage_md.sv
// exec_stage_md: TP4 EX stage with forwarding, single-cycle ALU and iterative mul/div (DIV/DIVU only when EXE_DIV_EN is defined)
module exec_stage_md #(
  parameter int W = 32,
  parameter int RW = 5,
  localparam int SH = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [W-1:0]  in_imm,
  input  logic          in_use_imm,
  input  logic [SH-1:0] in_shamt,
  input  logic          in_sh_var,
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wr,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_wr,
  input  logic [W-1:0]  mem_data,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_wr,
  input  logic [W-1:0]  wb_data,
  input  logic          stall_in,
  output logic          out_valid,
  output logic [W-1:0]  out_result,
  output logic [W-1:0]  out_storeb,
  output logic [RW-1:0] out_rd,
  output logic          out_wr,
  output logic          busy
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
  st_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] acc_q, acc_d, sr_q, sr_d, mb_q, mb_d, hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0] res_q, res_d, stb_q, stb_d;
  logic [RW-1:0] rd_q, rd_d;
  logic negp_q, negp_d, ov_q, ov_d, ow_q, ow_d;
`ifdef EXE_DIV_EN
  logic div_q, div_d, negr_q, negr_d, negr;
  logic [W:0] rem_sh;
  logic [W-1:0] rem_sub;
`endif
  logic [W-1:0] fwd_a, fwd_b, alu_b, alu_res, ma, mb, fin_hi, fin_lo, step_acc, step_sr;
  logic [SH-1:0] sh;
  logic wr_ok, is_md, sgn, na, nb, negp;
  logic [W:0] mul_sum;
  logic [2*W-1:0] prod;
  always_comb begin
    fwd_a = (mem_wr && mem_rd == in_rs && in_rs != '0) ? mem_data :
            (wb_wr && wb_rd == in_rs && in_rs != '0) ? wb_data : in_a;
    fwd_b = (mem_wr && mem_rd == in_rt && in_rt != '0) ? mem_data :
            (wb_wr && wb_rd == in_rt && in_rt != '0) ? wb_data : in_b;
    alu_b = in_use_imm ? in_imm : fwd_b;
    sh = in_sh_var ? fwd_a[SH-1:0] : in_shamt;
  end
  always_comb begin
    alu_res = '0;
    wr_ok = 1'b1;
    case (in_op)
      5'd0: alu_res = fwd_a + alu_b;
      5'd1: alu_res = fwd_a - alu_b;
      5'd2: alu_res = fwd_a & alu_b;
      5'd3: alu_res = fwd_a | alu_b;
      5'd4: alu_res = fwd_a ^ alu_b;
      5'd5: alu_res = ~(fwd_a | alu_b);
      5'd6: alu_res = {{(W-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
      5'd7: alu_res = {{(W-1){1'b0}}, fwd_a < alu_b};
      5'd8: alu_res = fwd_b << sh;
      5'd9: alu_res = fwd_b >> sh;
      5'd10: alu_res = $signed(fwd_b) >>> sh;
      5'd11: alu_res = alu_b << (W / 2);
      5'd12: alu_res = hi_q;
      5'd13: alu_res = lo_q;
      default: wr_ok = 1'b0;
    endcase
  end
  always_comb begin
    sgn = ~in_op[0];
    na = sgn & fwd_a[W-1];
    nb = sgn & fwd_b[W-1];
    ma = na ? -fwd_a : fwd_a;
    mb = nb ? -fwd_b : fwd_b;
    negp = na ^ nb;
`ifdef EXE_DIV_EN
    negr = na;
    is_md = in_op >= 5'd14 && in_op <= 5'd17;
    if (in_op[4] && fwd_b == '0) begin
      ma = fwd_a;
      negp = 1'b0;
      negr = 1'b0;
    end
`else
    is_md = in_op == 5'd14 || in_op == 5'd15;
`endif
  end
  always_comb begin
    mul_sum = {1'b0, acc_q} + {1'b0, mb_q & {W{sr_q[0]}}};
    step_acc = mul_sum[W:1];
    step_sr = {mul_sum[0], sr_q[W-1:1]};
    prod = negp_q ? -{acc_q, sr_q} : {acc_q, sr_q};
    fin_hi = prod[2*W-1:W];
    fin_lo = prod[W-1:0];
`ifdef EXE_DIV_EN
    rem_sh = {acc_q, sr_q[W-1]};
    rem_sub = rem_sh[W-1:0] - mb_q;
    if (div_q) begin
      step_acc = rem_sh >= {1'b0, mb_q} ? rem_sub : rem_sh[W-1:0];
      step_sr = {sr_q[W-2:0], rem_sh >= {1'b0, mb_q}};
      fin_lo = negp_q ? -sr_q : sr_q;
      fin_hi = negr_q ? -acc_q : acc_q;
    end
`endif
  end
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    sr_d = sr_q;
    mb_d = mb_q;
    negp_d = negp_q;
    hi_d = hi_q;
    lo_d = lo_q;
    ov_d = ov_q;
    ow_d = ow_q;
    res_d = res_q;
    stb_d = stb_q;
    rd_d = rd_q;
`ifdef EXE_DIV_EN
    div_d = div_q;
    negr_d = negr_q;
`endif
    if (!stall_in) begin
      ov_d = 1'b0;
      ow_d = 1'b0;
      case (st_q)
        IDLE: if (in_valid && is_md) begin
          st_d = RUN;
          cnt_d = CW'(W);
          acc_d = '0;
          sr_d = ma;
          mb_d = mb;
          negp_d = negp;
`ifdef EXE_DIV_EN
          div_d = in_op[4];
          negr_d = negr;
`endif
        end else if (in_valid) begin
          ov_d = 1'b1;
          ow_d = in_wr & wr_ok;
          res_d = alu_res;
          stb_d = fwd_b;
          rd_d = in_rd;
        end
        RUN: begin
          acc_d = step_acc;
          sr_d = step_sr;
          cnt_d = cnt_q - CW'(1);
          st_d = cnt_q == CW'(1) ? DONE : RUN;
        end
        DONE: begin
          st_d = IDLE;
          hi_d = fin_hi;
          lo_d = fin_lo;
          ov_d = 1'b1;
          res_d = fin_lo;
          stb_d = '0;
          rd_d = '0;
        end
        default: st_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      sr_q <= '0;
      mb_q <= '0;
      negp_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      ov_q <= 1'b0;
      ow_q <= 1'b0;
      res_q <= '0;
      stb_q <= '0;
      rd_q <= '0;
`ifdef EXE_DIV_EN
      div_q <= 1'b0;
      negr_q <= 1'b0;
`endif
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      sr_q <= sr_d;
      mb_q <= mb_d;
      negp_q <= negp_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      ov_q <= ov_d;
      ow_q <= ow_d;
      res_q <= res_d;
      stb_q <= stb_d;
      rd_q <= rd_d;
`ifdef EXE_DIV_EN
      div_q <= div_d;
      negr_q <= negr_d;
`endif
    end
  end
  assign in_ready = ~stall_in & (st_q == IDLE);
  assign busy = st_q != IDLE;
  assign out_valid = ov_q;
  assign out_wr = ow_q;
  assign out_result = res_q;
  assign out_storeb = stb_q;
  assign out_rd = rd_q;
endmodule

// File: tb/tb_exec_stage_md.sv
// tb_exec_stage_md: scoreboard bench for exec_stage_md against a behavioural arithmetic model
module tb_exec_stage_md;
  logic clk, rst, in_valid, in_ready, in_use_imm, in_sh_var, in_wr, mem_wr, wb_wr, stall_in;
  logic out_valid, out_wr, busy;
  logic [4:0] in_op, in_shamt, in_rs, in_rt, in_rd, mem_rd, wb_rd, out_rd;
  logic [31:0] in_a, in_b, in_imm, mem_data, wb_data, out_result, out_storeb;
  typedef struct {
    logic [31:0] res;
    logic [31:0] stb;
    logic [4:0] rd;
    logic wr;
    bit full;
    int due;
  } exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] hi_m = 0, lo_m = 0;
  exec_stage_md #(.W(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_shamt(in_shamt),
    .in_sh_var(in_sh_var), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_wr(in_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data(mem_data), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .wb_data(wb_data), .stall_in(stall_in), .out_valid(out_valid), .out_result(out_result),
    .out_storeb(out_storeb), .out_rd(out_rd), .out_wr(out_wr), .busy(busy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (r != 0 && mem_wr && mem_rd == r) return mem_data;
    if (r != 0 && wb_wr && wb_rd == r) return wb_data;
    return v;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic model(output exp_t e, output bit md);
    logic [31:0] fa, fb, bb, r;
    logic signed [31:0] sfb;
    logic [4:0] s;
    logic [63:0] p;
    int sa, sd;
    fa = fwd(in_rs, in_a);
    fb = fwd(in_rt, in_b);
    bb = in_use_imm ? in_imm : fb;
    sfb = fb;
    s = in_sh_var ? fa[4:0] : in_shamt;
    sa = fa;
    sd = fb;
    md = 0;
    r = 0;
    e.wr = in_wr;
    e.full = 1;
    e.due = cyc + 1;
    case (in_op)
      0: r = fa + bb;
      1: r = fa - bb;
      2: r = fa & bb;
      3: r = fa | bb;
      4: r = fa ^ bb;
      5: r = ~(fa | bb);
      6: r = ($signed(fa) < $signed(bb)) ? 32'd1 : 32'd0;
      7: r = (fa < bb) ? 32'd1 : 32'd0;
      8: r = fb << s;
      9: r = fb >> s;
      10: r = sfb >>> s;
      11: r = bb << 16;
      12: r = hi_m;
      13: r = lo_m;
      14: begin
        p = 64'(longint'(sa) * longint'(sd));
        md = 1;
      end
      15: begin
        p = {32'h0, fa} * {32'h0, fb};
        md = 1;
      end
`ifdef EXE_DIV_EN
      16: begin
        md = 1;
        if (fb == 0) p = {fa, 32'hFFFF_FFFF};
        else if (fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
        else p = {32'(sa % sd), 32'(sa / sd)};
      end
      17: begin
        md = 1;
        if (fb == 0) p = {fa, 32'hFFFF_FFFF};
        else p = {fa % fb, fa / fb};
      end
`endif
      default: begin
        r = 0;
        e.wr = 0;
        if (in_op == 16 || in_op == 17) e.full = 0;
      end
    endcase
    if (md) begin
      hi_m = p[63:32];
      lo_m = p[31:0];
      e.wr = 0;
      e.full = 0;
      e.due = cyc + 1 + 33;
    end
    e.res = r;
    e.stb = fb;
    e.rd = in_rd;
  endtask
  task automatic go(input int stall_at, input int stall_n, input int abort_at);
    exp_t e;
    bit md;
    int n;
    in_valid = 1;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 1);
    model(e, md);
    if (md) e.due += stall_n;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 0;
    if (md) begin
      chk("busy_run", 32'(busy), 1);
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
        if (n == stall_at) stall_in = 1;
        if (n == stall_at + stall_n) stall_in = 0;
        if (n == abort_at) begin
          rst = 1;
          sb.delete();
          @(posedge clk);
          #1;
          rst = 0;
          hi_m = 0;
          lo_m = 0;
          chk("abort_busy", 32'(busy), 0);
          chk("abort_ready", 32'(in_ready), 1);
          return;
        end
      end while (!in_ready && n < 120);
      chk("md_edges", n, 33 + stall_n);
    end
  endtask
  task automatic idle(input int n, input logic st);
    stall_in = st;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    stall_in = 0;
  endtask
  task automatic clr();
    {in_valid, in_use_imm, in_sh_var, in_wr, mem_wr, wb_wr, stall_in} = '0;
    {in_op, in_shamt, in_rs, in_rt, in_rd, mem_rd, wb_rd} = '0;
    {in_a, in_b, in_imm, mem_data, wb_data} = '0;
  endtask
  task automatic rd_hilo();
    in_op = 12;
    in_rd = 1;
    in_wr = 1;
    go(0, 0, 0);
    in_op = 13;
    in_rd = 2;
    go(0, 0, 0);
  endtask
  task automatic md_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    clr();
    in_op = op;
    in_a = a;
    in_b = b;
    go(0, 0, 0);
    rd_hilo();
  endtask
  exp_t me;
  logic ms, mr, pv, pw;
  logic [31:0] pres;
  initial begin
    forever begin
      @(posedge clk);
      ms = stall_in;
      mr = rst;
      cyc++;
      @(negedge clk);
      if (!mr) begin
        if (ms) begin
          chk("hold_valid", 32'(out_valid), 32'(pv));
          chk("hold_result", out_result, pres);
          chk("hold_wr", 32'(out_wr), 32'(pw));
        end else if (out_valid) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_retire: got out_valid=1 with nothing outstanding, required 0 (cycle %0d)", cyc);
          end else begin
            me = sb.pop_front();
            chk("retire_cycle", cyc, me.due);
            chk("out_wr", 32'(out_wr), 32'(me.wr));
            if (me.full) begin
              chk("out_result", out_result, me.res);
              chk("out_storeb", out_storeb, me.stb);
              chk("out_rd", 32'(out_rd), 32'(me.rd));
            end
          end
        end else chk("bubble_wr", 32'(out_wr), 0);
      end
      pv = out_valid;
      pres = out_result;
      pw = out_wr;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    logic [4:0] op;
    clr();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_wr", 32'(out_wr), 0);
    chk("rst_result", out_result, 0);
    chk("rst_rd", 32'(out_rd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    clr();
    in_a = 5;
    in_b = 7;
    in_rd = 3;
    in_wr = 1;
    go(0, 0, 0);
    idle(2, 1);
    clr();
    in_rs = 4;
    mem_rd = 4;
    wb_rd = 4;
    mem_wr = 1;
    wb_wr = 1;
    mem_data = 9;
    wb_data = 1;
    in_a = 100;
    in_wr = 1;
    in_rd = 6;
    go(0, 0, 0);
    mem_wr = 0;
    go(0, 0, 0);
    in_rs = 0;
    mem_rd = 0;
    wb_rd = 0;
    mem_wr = 1;
    go(0, 0, 0);
    md_op(14, 32'hFFFF_FFFD, 7);
    md_op(15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_op(14, 32'h8000_0000, 32'h8000_0000);
    md_op(16, 32'hFFFF_FFF9, 2);
    md_op(17, 10, 0);
    md_op(16, 32'h8000_0000, 32'hFFFF_FFFF);
    md_op(16, 7, 32'hFFFF_FFFE);
    md_op(16, 32'hFFFF_FFF0, 0);
    md_op(17, 32'hFFFF_FFF1, 16);
    clr();
    in_op = 14;
    in_a = 32'h1234_5678;
    in_b = 32'h9ABC_DEF0;
    go(5, 3, 0);
    rd_hilo();
    clr();
    in_op = 14;
    in_a = 123;
    in_b = 456;
    go(0, 0, 10);
    rd_hilo();
    clr();
    in_op = 10;
    in_b = 32'h8000_0000;
    in_shamt = 4;
    in_rd = 7;
    in_wr = 1;
    go(0, 0, 0);
    in_op = 11;
    in_use_imm = 1;
    in_imm = 32'h0000_ABCD;
    go(0, 0, 0);
    in_op = 20;
    go(0, 0, 0);
    for (int i = 0; i < 250; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op >= 14 && op <= 17 && $urandom_range(0, 2) != 0) op = 5'($urandom_range(0, 13));
      in_op = op;
      in_a = pick();
      in_b = pick();
      in_imm = pick();
      in_use_imm = 1'($urandom_range(0, 1));
      in_shamt = 5'($urandom);
      in_sh_var = 1'($urandom_range(0, 1));
      in_rs = 5'($urandom_range(0, 3));
      in_rt = 5'($urandom_range(0, 3));
      in_rd = 5'($urandom_range(0, 3));
      in_wr = 1'($urandom_range(0, 1));
      mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      mem_wr = 1'($urandom_range(0, 1));
      wb_wr = 1'($urandom_range(0, 1));
      mem_data = pick();
      wb_data = pick();
      go(0, 0, 0);
      if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end
    idle(3, 0);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
